// File: rtl/prog_loader.sv
// prog_loader: boot-time program loader in front of the processor's 128x16
// memory. Takes a byte stream (length, hi/lo byte pairs, XOR checksum),
// writes the assembled words from address 0 upward and only releases the
// processor once the checksum matches.
module prog_loader #(
  parameter int ADDR_W = 7,
  parameter int DEPTH  = 128
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              rx_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       mem_wdata,
  output logic              cpu_run,
  output logic              done,
  output logic              err
);

  typedef enum logic [2:0] {IDLE, LEN, HI, LO, WR, CHK, RUN, ERR} state_t;

  localparam logic [8:0] DEPTH_MAX = 9'(DEPTH);

  state_t     state, next_state;
  logic [7:0] count;
  logic [7:0] n_words;
  logic [7:0] hi_byte;
  logic [7:0] csum;
  logic       xfer;
  logic       len_ok;
  logic       last_word;

  // A byte only counts when it is handshaken and no restart is requested.
  assign rx_ready  = (state == LEN) || (state == HI) || (state == LO) || (state == CHK);
  assign xfer      = rx_valid && rx_ready && !start;
  assign len_ok    = (rx_data != 8'd0) && ({1'b0, rx_data} <= DEPTH_MAX);
  assign last_word = (count + 8'd1) == n_words;

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= next_state;
  end

  // Next-state logic: start overrides everything, bytes advance the FSM only on transfer.
  always_comb begin
    next_state = state;
    if (start) begin
      next_state = LEN;
    end else begin
      case (state)
        IDLE:     next_state = IDLE;
        LEN:      if (xfer) next_state = len_ok ? HI : ERR;
        HI:       if (xfer) next_state = LO;
        LO:       if (xfer) next_state = WR;
        WR:       next_state = last_word ? CHK : HI;
        CHK:      if (xfer) next_state = (rx_data == csum) ? RUN : ERR;
        RUN, ERR: next_state = state;
        default:  next_state = IDLE;
      endcase
    end
  end

  // Datapath: length/byte latches, checksum, registered write port and status flags.
  // The low byte goes straight into the write-data register so the word is
  // presented during the WR cycle that follows its transfer.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count     <= '0;
      n_words   <= '0;
      hi_byte   <= '0;
      csum      <= '0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      cpu_run   <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      mem_we  <= 1'b0;
      cpu_run <= (next_state == RUN);
      done    <= (next_state == RUN);
      err     <= (next_state == ERR);
      if (start) begin
        count <= '0;
        csum  <= '0;
      end else begin
        case (state)
          LEN: if (xfer && len_ok) n_words <= rx_data;
          HI: if (xfer) begin
            hi_byte <= rx_data;
            csum    <= csum ^ rx_data;
          end
          LO: if (xfer) begin
            csum      <= csum ^ rx_data;
            mem_we    <= 1'b1;
            mem_addr  <= count[ADDR_W-1:0];
            mem_wdata <= {hi_byte, rx_data};
          end
          WR:      count <= count + 8'd1;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader: drives byte streams (directed and $urandom) into
// prog_loader and checks every cycle against a transaction-level model that
// interprets the stream by byte position (length, data pairs, checksum).
module tb_prog_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        rx_ready;
  logic        mem_we;
  logic [6:0]  mem_addr;
  logic [15:0] mem_wdata;
  logic        cpu_run;
  logic        done;
  logic        err;

  prog_loader #(.ADDR_W(7), .DEPTH(128)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .rx_valid  (rx_valid),
    .rx_data   (rx_data),
    .rx_ready  (rx_ready),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .cpu_run   (cpu_run),
    .done      (done),
    .err       (err)
  );

  typedef struct packed {
    int          wcyc;
    logic [6:0]  addr;
    logic [15:0] data;
  } wr_t;

  int          cyc = 0;
  int          vectors = 0;
  int          miscompares = 0;
  int          wr_count = 0;
  int          wr_before;
  wr_t         exp_q[$];
  logic [7:0]  txq[$];
  logic [15:0] obs_mem [0:127];
  bit          rand_valid = 1'b0;
  bit          took;

  // Model of the load: position in stream, expected flags and ready.
  int          m_idx;
  int          m_n;
  int          m_words;
  int          m_wr_cycle;
  logic [7:0]  m_hi;
  logic [7:0]  m_csum;
  bit          m_ready;
  bit          m_run;
  bit          m_err;

  // Free-running clock.
  always #5 clk = ~clk;

  // Cycle number, equal to the number of rising edges seen so far.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic modelReset();
    m_idx = 0; m_n = 0; m_words = 0; m_wr_cycle = -1;
    m_hi = 8'h00; m_csum = 8'h00;
    m_ready = 1'b0; m_run = 1'b0; m_err = 1'b0;
    exp_q.delete();
  endtask

  task automatic modelStart();
    modelReset();
    m_ready = 1'b1;
  endtask

  // Interpret one transferred byte by its position in the stream.
  task automatic modelByte(input logic [7:0] d);
    if (m_idx == 0) begin
      if (d == 8'd0 || d > 8'd128) begin
        m_ready = 1'b0;
        m_err   = 1'b1;
      end else begin
        m_n = int'(d);
      end
      m_idx = 1;
    end else if (m_idx <= 2 * m_n) begin
      m_csum = m_csum ^ d;
      if (m_idx % 2 == 1) begin
        m_hi = d;
      end else begin
        exp_q.push_back('{wcyc: cyc, addr: 7'(m_words), data: {m_hi, d}});
        m_wr_cycle = cyc;
        m_words++;
      end
      m_idx++;
    end else begin
      m_ready = 1'b0;
      if (d == m_csum) m_run = 1'b1;
      else             m_err = 1'b1;
    end
  endtask

  // One clock of stimulus, driven just after a rising edge; model follows the edge.
  task automatic applyStimulus(input bit s, input bit v, input logic [7:0] d);
    start    = s;
    rx_valid = v;
    rx_data  = d;
    took     = v && rx_ready && !s;
    @(posedge clk);
    #1;
    start    = 1'b0;
    rx_valid = 1'b0;
    if (s)         modelStart();
    else if (took) modelByte(d);
  endtask

  task automatic sendByte(input logic [7:0] d);
    int tries;
    tries = 0;
    took  = 1'b0;
    while (!took && tries < 40) begin
      applyStimulus(1'b0, rand_valid ? ($urandom_range(0, 3) != 0) : 1'b1, d);
      tries++;
    end
    if (!took) begin
      vectors++;
      miscompares++;
      $display("[TB] FAIL byte_timeout: byte %02h not accepted after %0d cycles, expected acceptance", d, tries);
      m_ready = 1'b0;
    end
  endtask

  task automatic sendQueue();
    for (int i = 0; i < txq.size(); i++) begin
      if (!m_ready) break;
      sendByte(txq[i]);
    end
  endtask

  task automatic buildLoad(input int n, input bit pattern, input bit corrupt);
    logic [7:0] cs;
    logic [7:0] b;
    cs = 8'h00;
    txq.delete();
    txq.push_back(8'(n));
    for (int k = 0; k < 2 * n; k++) begin
      b = pattern ? 8'(k / 2) : 8'($urandom_range(0, 255));
      cs = cs ^ b;
      txq.push_back(b);
    end
    txq.push_back(corrupt ? (cs ^ 8'h01) : cs);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 8'h00);
  endtask

  // Per-cycle compare: writes against the expected queue, ready and status flags against the model.
  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      wr_count++;
      obs_mem[mem_addr] = mem_wdata;
      if (exp_q.size() > 0 && exp_q[0].wcyc == cyc) begin
        checkOutput("wr_addr", 32'(mem_addr), 32'(exp_q[0].addr));
        checkOutput("wr_data", 32'(mem_wdata), 32'(exp_q[0].data));
        void'(exp_q.pop_front());
      end else begin
        checkOutput("wr_strobe_spurious", 32'(mem_we), 32'd0);
      end
    end else if (exp_q.size() > 0 && exp_q[0].wcyc == cyc) begin
      checkOutput("wr_strobe_missing", 32'(mem_we), 32'd1);
      void'(exp_q.pop_front());
    end
    checkOutput("rx_ready", 32'(rx_ready), 32'(m_ready && (cyc != m_wr_cycle)));
    checkOutput("cpu_run", 32'(cpu_run), 32'(m_run));
    checkOutput("done", 32'(done), 32'(m_run));
    checkOutput("err", 32'(err), 32'(m_err));
  end

  // Directed scenarios followed by randomized loads.
  initial begin
    reset = 1'b0; start = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
    modelReset();
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_cpu_run", 32'(cpu_run), 32'd0);
    checkOutput("reset_done", 32'(done), 32'd0);
    checkOutput("reset_err", 32'(err), 32'd0);
    checkOutput("reset_rx_ready", 32'(rx_ready), 32'd0);
    checkOutput("reset_mem_we", 32'(mem_we), 32'd0);
    reset = 1'b1;
    idle(2);

    $display("[TB] good load N=2");
    applyStimulus(1'b1, 1'b1, 8'h77);
    txq = '{8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h40};
    sendQueue();
    idle(1);
    checkOutput("t1_mem0", 32'(obs_mem[0]), 32'h1234);
    checkOutput("t1_mem1", 32'(obs_mem[1]), 32'hABCD);
    checkOutput("t1_cpu_run", 32'(cpu_run), 32'd1);
    checkOutput("t1_done", 32'(done), 32'd1);
    checkOutput("t1_err", 32'(err), 32'd0);

    $display("[TB] bad checksum");
    wr_before = wr_count;
    applyStimulus(1'b1, 1'b0, 8'h00);
    txq = '{8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h41};
    sendQueue();
    idle(1);
    checkOutput("t2_writes", 32'(wr_count - wr_before), 32'd2);
    checkOutput("t2_err", 32'(err), 32'd1);
    checkOutput("t2_cpu_run", 32'(cpu_run), 32'd0);
    checkOutput("t2_done", 32'(done), 32'd0);
    applyStimulus(1'b1, 1'b0, 8'h00);
    checkOutput("t2_restart_err", 32'(err), 32'd0);
    checkOutput("t2_restart_ready", 32'(rx_ready), 32'd1);

    $display("[TB] bad length bytes");
    wr_before = wr_count;
    txq = '{8'h00};
    sendQueue();
    idle(1);
    checkOutput("t3_len00_err", 32'(err), 32'd1);
    applyStimulus(1'b1, 1'b0, 8'h00);
    txq = '{8'h81};
    sendQueue();
    idle(1);
    checkOutput("t3_len81_err", 32'(err), 32'd1);
    checkOutput("t3_no_writes", 32'(wr_count - wr_before), 32'd0);

    $display("[TB] full 128-word load with random stalls");
    rand_valid = 1'b1;
    wr_before = wr_count;
    applyStimulus(1'b1, 1'b0, 8'h00);
    buildLoad(128, 1'b1, 1'b0);
    sendQueue();
    idle(1);
    checkOutput("t4_writes", 32'(wr_count - wr_before), 32'd128);
    checkOutput("t4_mem0", 32'(obs_mem[0]), 32'h0000);
    checkOutput("t4_mem5", 32'(obs_mem[5]), 32'h0505);
    checkOutput("t4_mem127", 32'(obs_mem[127]), 32'h7F7F);
    checkOutput("t4_cpu_run", 32'(cpu_run), 32'd1);

    $display("[TB] abort after high byte of word 3");
    rand_valid = 1'b0;
    applyStimulus(1'b1, 1'b0, 8'h00);
    txq = '{8'h05, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07};
    sendQueue();
    applyStimulus(1'b1, 1'b1, 8'h08);
    txq = '{8'h01, 8'h5A, 8'hA5, 8'hFF};
    sendQueue();
    idle(1);
    checkOutput("t5_mem0", 32'(obs_mem[0]), 32'h5AA5);
    checkOutput("t5_mem2", 32'(obs_mem[2]), 32'h0506);
    checkOutput("t5_mem3_untouched", 32'(obs_mem[3]), 32'h0303);
    checkOutput("t5_cpu_run", 32'(cpu_run), 32'd1);

    $display("[TB] async reset while running");
    reset = 1'b0;
    #1;
    checkOutput("t6_cpu_run", 32'(cpu_run), 32'd0);
    checkOutput("t6_done", 32'(done), 32'd0);
    checkOutput("t6_mem_we", 32'(mem_we), 32'd0);
    checkOutput("t6_rx_ready", 32'(rx_ready), 32'd0);
    modelReset();
    applyStimulus(1'b0, 1'b1, 8'h55);
    applyStimulus(1'b0, 1'b1, 8'h55);
    reset = 1'b1;
    applyStimulus(1'b0, 1'b1, 8'h55);
    applyStimulus(1'b0, 1'b1, 8'h55);
    checkOutput("t6_idle_ready", 32'(rx_ready), 32'd0);

    $display("[TB] randomized loads");
    rand_valid = 1'b1;
    for (int r = 0; r < 8; r++) begin
      applyStimulus(1'b1, $urandom_range(0, 1) == 1, 8'($urandom_range(0, 255)));
      if ($urandom_range(0, 5) == 0) begin
        txq.delete();
        txq.push_back(8'($urandom_range(129, 255)));
      end else begin
        buildLoad($urandom_range(1, 16), 1'b0, $urandom_range(0, 2) == 0);
      end
      sendQueue();
      idle(2);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
